// File: rtl/mmio_port_controller.sv
// Memory-mapped I/O port block: synchronised input words, byte-merged output registers,
// registered read path with error reporting. Optional change detection via MMIO_CHANGE_DETECT_EN.
module mmio_port_controller #(
  parameter int unsigned NUM_PORTS          = 8,
  parameter logic [31:0] BASE_ADDRESS       = 32'hFFFFFFE0,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter logic [31:0] OUTPUT_RESET_VALUE = 32'h00000000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      access_valid,
  input  logic                      access_write,
  input  logic [31:0]               access_address,
  input  logic [1:0]                access_size,
  input  logic [31:0]               write_data,
  output logic [31:0]               read_data,
  output logic                      read_valid,
  output logic                      access_hit,
  output logic                      access_error,
  input  logic [NUM_PORTS*32-1:0]   mmio_inputs,
  output logic [NUM_PORTS*32-1:0]   mmio_outputs,
  output logic [NUM_PORTS-1:0]      write_strobe,
  output logic                      change_pending
);

  localparam int unsigned IW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] WIN_MASK = ~(32'(4 * NUM_PORTS) - 32'd1);

  logic [31:0]          sync_q [SYNC_STAGES][NUM_PORTS];
  logic [31:0]          out_q  [NUM_PORTS];
  logic [31:0]          out_d  [NUM_PORTS];
  logic [31:0]          read_data_q, read_data_d;
  logic                 read_valid_q, hit_q, error_q;
  logic [NUM_PORTS-1:0] strobe_q, strobe_d;

  logic          in_window, aligned, legal_hit, do_write, do_read;
  logic [IW-1:0] port_idx;
  logic [1:0]    off;
  logic [31:0]   in_word, shifted, rd_sized, wshift;
  logic [3:0]    be;

  assign in_window = (access_address & WIN_MASK) == BASE_ADDRESS;
  assign port_idx  = (NUM_PORTS > 1) ? access_address[2 +: IW] : '0;
  assign off       = access_address[1:0];

  always_comb begin
    aligned = 1'b0;
    case (access_size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal_hit = access_valid & in_window & aligned;
  assign do_write  = legal_hit & access_write;
  assign do_read   = access_valid & ~access_write;

  // Reads always see the last synchroniser stage, never the output registers.
  assign in_word = sync_q[SYNC_STAGES-1][port_idx];
  assign shifted = in_word >> {off, 3'b000};
  assign wshift  = write_data << {off, 3'b000};

  always_comb begin
    rd_sized = shifted;
    be       = 4'b1111;
    case (access_size)
      2'b00: begin
        rd_sized = {24'b0, shifted[7:0]};
        be       = 4'b0001 << off;
      end
      2'b01: begin
        rd_sized = {16'b0, shifted[15:0]};
        be       = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  always_comb begin
    read_data_d = read_data_q;
    if (do_read) read_data_d = legal_hit ? rd_sized : 32'b0;
    strobe_d = '0;
    if (do_write) strobe_d[port_idx] = 1'b1;
    out_d = out_q;
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) out_d[port_idx][8*b +: 8] = wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++)
        for (int p = 0; p < int'(NUM_PORTS); p++) sync_q[s][p] <= '0;
      for (int p = 0; p < int'(NUM_PORTS); p++) out_q[p] <= OUTPUT_RESET_VALUE;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      hit_q        <= 1'b0;
      error_q      <= 1'b0;
      strobe_q     <= '0;
    end else begin
      for (int p = 0; p < int'(NUM_PORTS); p++) sync_q[0][p] <= mmio_inputs[32*p +: 32];
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      out_q        <= out_d;
      read_data_q  <= read_data_d;
      read_valid_q <= do_read;
      hit_q        <= access_valid & in_window;
      error_q      <= access_valid & in_window & ~aligned;
      strobe_q     <= strobe_d;
    end
  end

  for (genvar g = 0; g < int'(NUM_PORTS); g++) begin : g_out
    assign mmio_outputs[32*g +: 32] = out_q[g];
  end

  assign read_data    = read_data_q;
  assign read_valid   = read_valid_q;
  assign access_hit   = hit_q;
  assign access_error = error_q;
  assign write_strobe = strobe_q;

`ifdef MMIO_CHANGE_DETECT_EN
  logic [31:0]          prev_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] flag_q, flag_d;

  // A change arriving on the same edge as the clearing read keeps the flag set.
  always_comb begin
    flag_d = flag_q;
    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      flag_d[p] = (sync_q[SYNC_STAGES-1][p] != prev_q[p]) |
                  (flag_q[p] & ~(do_read & legal_hit & (port_idx == IW'(p))));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < int'(NUM_PORTS); p++) prev_q[p] <= '0;
      flag_q <= '0;
    end else begin
      prev_q <= sync_q[SYNC_STAGES-1];
      flag_q <= flag_d;
    end
  end

  assign change_pending = |flag_q;
`else
  assign change_pending = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_port_controller.sv
// Bench for mmio_port_controller: directed vector table, latency/reset sequences and
// randomized accesses checked against a byte-level model with an input-history queue.
module tb_mmio_port_controller;
  localparam int          NP   = 8;
  localparam logic [31:0] BASE = 32'hFFFFFFE0;
  localparam int          SS   = 2;
  localparam int          EW   = 35 + NP;

  logic              clock, reset, access_valid, access_write;
  logic [31:0]       access_address, write_data, read_data;
  logic [1:0]        access_size;
  logic              read_valid, access_hit, access_error, change_pending;
  logic [NP*32-1:0]  mmio_inputs, mmio_outputs;
  logic [NP-1:0]     write_strobe;

  mmio_port_controller #(.NUM_PORTS(NP), .BASE_ADDRESS(BASE), .SYNC_STAGES(SS),
                         .OUTPUT_RESET_VALUE(32'h0)) dut (
    .clock(clock), .reset(reset), .access_valid(access_valid), .access_write(access_write),
    .access_address(access_address), .access_size(access_size), .write_data(write_data),
    .read_data(read_data), .read_valid(read_valid), .access_hit(access_hit),
    .access_error(access_error), .mmio_inputs(mmio_inputs), .mmio_outputs(mmio_outputs),
    .write_strobe(write_strobe), .change_pending(change_pending));

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // scoreboard and reference model
  logic [EW-1:0]    exp_q[$];
  logic [NP*32-1:0] hist[$];
  logic [31:0]      out_m [NP];
  logic [31:0]      prev_vis [NP];
  logic [NP-1:0]    flag_m;
  logic [31:0]      last_rd;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value a read issued now sees: the input driven SS cycles ago (zero before that).
  function automatic logic [31:0] vis_word(input int p);
    logic [NP*32-1:0] snap;
    if (hist.size() <= SS) return 32'h0;
    snap = hist[hist.size() - 1 - SS];
    return snap[32*p +: 32];
  endfunction

  // driver: one access per call, called at a falling edge, returns at the next falling edge
  task automatic cycle(input logic rst, input logic v, input logic w,
                       input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    logic [EW-1:0]    exp, got;
    logic [NP*32-1:0] out_flat;
    logic [31:0]      rd, wd;
    logic [NP-1:0]    stb;
    longint           rel;
    int               p, ob, nb;
    logic             in_win, legal, hit, err, rv;
    reset = rst; access_valid = v; access_write = w;
    access_address = a; access_size = s; write_data = d;
    if (rst) begin
      exp = '0;
      hist.delete();
      for (int i = 0; i < NP; i++) begin out_m[i] = '0; prev_vis[i] = '0; end
      flag_m = '0;
      last_rd = '0;
    end else begin
      hist.push_back(mmio_inputs);
      rel    = longint'(a) - longint'(BASE);
      in_win = (rel >= 0) && (rel < 4 * NP);
      p      = in_win ? int'(rel) / 4 : 0;
      ob     = int'(a % 32'd4);
      nb     = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      legal  = (s != 2'd3) && (ob % nb == 0);
      hit    = v && in_win;
      err    = hit && !legal;
      rv     = v && !w;
      rd     = last_rd;
      stb    = '0;
      if (rv) begin
        rd = 32'h0;
        if (in_win && legal) begin
          wd = vis_word(p);
          for (int k = 0; k < nb; k++) rd |= ((wd >> (8 * (ob + k))) & 32'hFF) << (8 * k);
        end
      end
      if (v && w && in_win && legal) begin
        for (int k = 0; k < nb; k++) out_m[p][8*(ob+k) +: 8] = d[8*k +: 8];
        stb[p] = 1'b1;
      end
`ifdef MMIO_CHANGE_DETECT_EN
      for (int i = 0; i < NP; i++) begin
        wd = vis_word(i);
        flag_m[i] = (wd != prev_vis[i]) || (flag_m[i] && !(rv && in_win && legal && p == i));
        prev_vis[i] = wd;
      end
`endif
      last_rd = rd;
      exp = {rv, rd, hit, err, stb};
    end
    exp_q.push_back(exp);
    @(negedge clock);
    got = {read_valid, read_data, access_hit, access_error, write_strobe};
    chk("scoreboard", 256'(got), 256'(exp_q.pop_front()));
    for (int i = 0; i < NP; i++) out_flat[32*i +: 32] = out_m[i];
    chk("outputs", 256'(mmio_outputs), 256'(out_flat));
    chk("change_pending", 256'(change_pending), 256'(|flag_m));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
    logic        hit, err, rv;
    logic [31:0] rd;
    logic [NP-1:0] stb;
    logic [31:0] p1;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{1'b0, 32'hFFFFFFE0, 2'd2, 32'h0,        1, 0, 1, 32'hDEADBEEF, 8'h00, 32'h0};
    vt[1]  = '{1'b1, 32'hFFFFFFE4, 2'd2, 32'h12345678, 1, 0, 0, 32'hDEADBEEF, 8'h02, 32'h12345678};
    vt[2]  = '{1'b1, 32'hFFFFFFE6, 2'd0, 32'h000000AB, 1, 0, 0, 32'hDEADBEEF, 8'h02, 32'h12AB5678};
    vt[3]  = '{1'b0, 32'hFFFFFFFE, 2'd1, 32'h0,        1, 0, 1, 32'h00008001, 8'h00, 32'h12AB5678};
    vt[4]  = '{1'b0, 32'hFFFFFFFD, 2'd1, 32'h0,        1, 1, 1, 32'h00000000, 8'h00, 32'h12AB5678};
    vt[5]  = '{1'b1, 32'h00001000, 2'd2, 32'hFFFFFFFF, 0, 0, 0, 32'h00000000, 8'h00, 32'h12AB5678};
    vt[6]  = '{1'b1, 32'hFFFFFFE0, 2'd3, 32'h55555555, 1, 1, 0, 32'h00000000, 8'h00, 32'h12AB5678};
    vt[7]  = '{1'b0, 32'hFFFFFFE3, 2'd0, 32'h0,        1, 0, 1, 32'h000000DE, 8'h00, 32'h12AB5678};
    vt[8]  = '{1'b0, 32'h00001000, 2'd0, 32'h0,        0, 0, 1, 32'h00000000, 8'h00, 32'h12AB5678};
    vt[9]  = '{1'b0, 32'hFFFFFFE2, 2'd1, 32'h0,        1, 0, 1, 32'h0000DEAD, 8'h00, 32'h12AB5678};
    vt[10] = '{1'b1, 32'hFFFFFFE5, 2'd1, 32'h0000BEEF, 1, 1, 0, 32'h0000DEAD, 8'h00, 32'h12AB5678};
    vt[11] = '{1'b1, 32'hFFFFFFE6, 2'd1, 32'h0000C0DE, 1, 0, 0, 32'h0000DEAD, 8'h02, 32'hC0DE5678};

    mmio_inputs = '0;
    @(negedge clock);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 2'd0, 32'h0);
    chk("reset_state", 256'({read_valid, read_data, access_hit, access_error, write_strobe,
                             mmio_outputs}), 256'(0));

    // directed vector table
    mmio_inputs[31:0]    = 32'hDEADBEEF;
    mmio_inputs[255:224] = 32'h8001C0DE;
    idle(SS + 2);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, vt[i].w, vt[i].a, vt[i].s, vt[i].d);
      chk($sformatf("vec%0d", i),
          256'({access_hit, access_error, read_valid, read_data, write_strobe, mmio_outputs[63:32]}),
          256'({vt[i].hit, vt[i].err, vt[i].rv, vt[i].rd, vt[i].stb, vt[i].p1}));
    end
    chk("port0_unchanged", 256'(mmio_outputs[31:0]), 256'(0));

    // input latency: port 3 changes at cycle t, reads issued every cycle from t
    mmio_inputs[127:96] = 32'h11111111;
    idle(SS + 2);
    for (int c = 0; c < 4; c++) begin
      if (c == 0) mmio_inputs[127:96] = 32'h22222222;
      cycle(1'b0, 1'b1, 1'b0, 32'hFFFFFFEC, 2'd2, 32'h0);
      chk($sformatf("latency_t%0d", c), 256'(read_data),
          256'((c < SS) ? 32'h11111111 : 32'h22222222));
    end

    // reset arriving together with a write: reset wins
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFFFFF4, 2'd2, 32'hAAAA5555);
    chk("pre_reset_write", 256'(mmio_outputs[191:160]), 256'(32'hAAAA5555));
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFFFFF4, 2'd2, 32'h12345678);
    chk("mid_reset", 256'({read_valid, read_data, access_hit, access_error, write_strobe,
                           mmio_outputs}), 256'(0));
    idle(SS + 2);

    // change detection: clear every flag, toggle port 2, then read it back
    for (int i = 0; i < NP; i++) cycle(1'b0, 1'b1, 1'b0, BASE + 32'(4 * i), 2'd2, 32'h0);
    mmio_inputs[95:64] = ~mmio_inputs[95:64];
    idle(SS + 2);
`ifdef MMIO_CHANGE_DETECT_EN
    chk("change_set", 256'(change_pending), 256'(1));
    cycle(1'b0, 1'b1, 1'b0, 32'hFFFFFFE8, 2'd2, 32'h0);
    chk("change_clear", 256'(change_pending), 256'(0));
`else
    chk("change_off", 256'(change_pending), 256'(0));
    cycle(1'b0, 1'b1, 1'b0, 32'hFFFFFFE8, 2'd2, 32'h0);
    chk("change_off_read", 256'(change_pending), 256'(0));
`endif

    // randomized accesses with inputs wandering underneath
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 3) == 0) mmio_inputs[32*$urandom_range(0, NP-1) +: 32] = $urandom;
      a = ($urandom_range(0, 4) != 0) ? BASE + 32'($urandom_range(0, 4*NP-1)) : 32'($urandom);
      cycle(1'b0 | ($urandom_range(0, 99) == 0), 1'($urandom_range(0, 5) != 0),
            1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 32'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
